// File: rtl/seq_multiplier_if.sv
// Handshake/data bundle between the control unit (master) and the
// sequential multiplier (slave).
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic [WIDTH-1:0] RESULT_HI;

    modport master (
        output START, DATA1, DATA2,
        input  BUSY, DONE, RESULT, RESULT_HI
    );

    modport slave (
        input  START, DATA1, DATA2,
        output BUSY, DONE, RESULT, RESULT_HI
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier for the ALU MUL path.
// The accumulate step runs through a 2*WIDTH-bit ripple chain of fullAdder
// cells. Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as
// the remaining multiplier bits are all zero.
//
// state  | meaning
// IDLE   | waiting for START; result of the last multiply is held
// RUN    | one shift-add iteration per edge, BUSY=1
// DONE   | one-cycle DONE pulse, then back to IDLE

module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    seq_multiplier_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;

    logic [PW-1:0]    sum_d;
    logic [PW-1:0]    chain_d;
    logic             carry_unused;
    logic             last_iter_d;

    // Ripple-carry accumulate: acc + mcand, carry-in 0, top carry dropped.
    assign chain_d[0] = 1'b0;
    for (genvar i = 0; i < PW; i++) begin : g_fa
        if (i < PW - 1) begin : g_mid
            fullAdder u_fa (
                .a    (acc_q[i]),
                .b    (mcand_q[i]),
                .cin  (chain_d[i]),
                .sum  (sum_d[i]),
                .cout (chain_d[i+1])
            );
        end else begin : g_msb
            fullAdder u_fa (
                .a    (acc_q[i]),
                .b    (mcand_q[i]),
                .cin  (chain_d[i]),
                .sum  (sum_d[i]),
                .cout (carry_unused)
            );
        end
    end

    // Decide whether the current RUN edge is the final iteration.
    always_comb begin
        last_iter_d = (count_q == CW'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (mplier_q[WIDTH-1:1] == '0) begin
            last_iter_d = 1'b1;
        end
`endif
    end

    // Control FSM and datapath registers with registered BUSY/DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.DATA1};
                        mplier_q <= bus.DATA2;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= sum_d;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (last_iter_d) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.RESULT    = acc_q[WIDTH-1:0];
    assign bus.RESULT_HI = acc_q[PW-1:WIDTH];
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against a plain
// arithmetic reference (product = a*b, latency from the multiplier value).
module tb_seq_multiplier;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Number of RUN cycles the reference expects for multiplier value b.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (b[i]) p = i;
        return p + 1;
`else
        return W;
`endif
    endfunction

    // Issue one multiply and check BUSY length, DONE timing, product and hold.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        int busy_cnt;
        int done_at;
        int done_cnt;
        int lat;
        logic [2*W-1:0] prod;
        lat  = exp_lat(b);
        prod = 16'(a) * 16'(b);
        @(negedge clk);
        bus.START = 1'b1;
        bus.DATA1 = a;
        bus.DATA2 = b;
        @(negedge clk);
        bus.START = 1'b0;
        busy_cnt  = 0;
        done_at   = 0;
        done_cnt  = 0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.DONE === 1'b1) begin
                done_at = c;
                done_cnt++;
            end
            bus.START = 1'b0;
            if (poke && c == 3) begin
                bus.DATA1 = 8'd9;
                bus.DATA2 = 8'd9;
                bus.START = 1'b1;
            end
            if (done_at == 0) @(negedge clk);
        end
        bus.START = 1'b0;
        check("done_cycle", 32'(done_at), 32'(lat + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(lat));
        check("busy_in_done", 32'(bus.BUSY), 32'd0);
        check("result_lo", 32'(bus.RESULT), 32'(prod[W-1:0]));
        check("result_hi", 32'(bus.RESULT_HI), 32'(prod[2*W-1:W]));
        // After DONE: no second pulse, no restart, result held.
        for (int c = 0; c < (poke ? 12 : 2); c++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) done_cnt++;
            if (bus.BUSY === 1'b1) busy_cnt++;
        end
        check("single_done", 32'(done_cnt), 32'd1);
        check("no_restart", 32'(busy_cnt), 32'(lat));
        check("hold_result", 32'({bus.RESULT_HI, bus.RESULT}), 32'(prod));
    endtask

    initial begin
        bit seen_done;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.START = 1'b1;
        bus.DATA1 = 8'd5;
        bus.DATA2 = 8'd7;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_result", 32'({bus.RESULT_HI, bus.RESULT}), 32'd0);
        rst       = 1'b0;
        bus.START = 1'b0;
        @(negedge clk);
        check("rst_no_accept", 32'(bus.BUSY), 32'd0);

        do_mult(8'd3, 8'd5, 1'b0);
        do_mult(8'hFF, 8'hFF, 1'b0);
        do_mult(8'h80, 8'h02, 1'b0);
        do_mult(8'd4, 8'd4, 1'b1);
        do_mult(8'd3, 8'd2, 1'b0);
        do_mult(8'd0, 8'd77, 1'b0);
        do_mult(8'd91, 8'd0, 1'b0);

        // Reset in the middle of a 7*9 multiply.
        @(negedge clk);
        bus.START = 1'b1;
        bus.DATA1 = 8'd7;
        bus.DATA2 = 8'd9;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_done", 32'(bus.DONE), 32'd0);
        check("midrst_result", 32'({bus.RESULT_HI, bus.RESULT}), 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) seen_done = 1'b1;
        end
        check("midrst_quiet", 32'(seen_done), 32'd0);
        do_mult(8'd2, 8'd3, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (t % 7 == 0) rb = W'(1) << $urandom_range(0, W - 1);
            do_mult(ra, rb, 1'(t % 5 == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multi-cycle unsigned shift-add multiplier for the ALU's MUL path. Sits directly downstream of the fullAdder cells and consumes them.
- Each iteration adds the shifted multiplicand into the accumulator through a 2*WIDTH-bit ripple chain built only from fullAdder instances. No "+" operator is used in the datapath.
- The control unit issues START and stalls the PC write while BUSY is high. It then takes RESULT (low byte) as the register-file write data.

Parameters:
- WIDTH, 8, operand width in bits. The product is 2*WIDTH bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request a multiply; sampled only in IDLE.
- DATA1  input  WIDTH  multiplicand, unsigned.
- DATA2  input  WIDTH  multiplier, unsigned.
- BUSY  output  1  high while iterating (RUN state).
- DONE  output  1  one-cycle pulse; RESULT/RESULT_HI are valid.
- RESULT  output  WIDTH  low WIDTH bits of the product.
- RESULT_HI  output  WIDTH  high WIDTH bits of the product.

Behaviour:
- Reset: RESET=1 at a rising edge forces state=IDLE, accumulator=0, count=0, BUSY=0, DONE=0, RESULT=0, RESULT_HI=0.
  - Applies from any state; an in-flight multiply is discarded.
- States:
  - IDLE: BUSY=0, DONE=0.
    - START=1 at edge E0: latch MCAND={WIDTH'b0,DATA1}, MPLIER=DATA2; clear accumulator and count; go to RUN.
    - START=0: stay in IDLE.
  - RUN: BUSY=1. One iteration per edge:
    - If MPLIER[0]=1, accumulator <= accumulator + MCAND through the fullAdder chain; carry-in=0 and the final carry-out is discarded.
    - MCAND <= MCAND<<1; MPLIER <= MPLIER>>1; count <= count+1.
    - After the iteration with count==WIDTH-1, go to DONE.
  - DONE: BUSY=0, DONE=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- Latency: START sampled at E0; RUN iterations at E1..E(WIDTH); DONE high during the cycle after E(WIDTH). With WIDTH=8, DONE is high in cycle 9.
- Result visibility: {RESULT_HI,RESULT} are driven from the accumulator and become final on the last RUN edge. They hold their value through DONE and IDLE until the next accepted START clears the accumulator.
- START outside IDLE (RUN or DONE) is ignored. No queuing, no restart.
- DATA1/DATA2 are only sampled at the START-accept edge; changes during RUN have no effect.
- Boundaries:
  - Zero operand gives product 0 with full latency.
  - 255*255 = 0xFE01 with no overflow; 2*WIDTH bits always suffice.
  - count is clog2(WIDTH)+1 bits wide and never wraps.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: RUN also goes to DONE after any iteration whose shifted MPLIER (MPLIER>>1) is zero. Latency then equals the bit position of the multiplier's MSB set bit plus 1 RUN cycles.
  - DATA2=0 still takes exactly 1 RUN cycle.
  - Result values are identical to the non-macro build.
- Undefined: always exactly WIDTH RUN cycles.

Test Plan:
- Reset check: hold RESET=1 for 2 cycles -> BUSY=0, DONE=0, RESULT=0x00, RESULT_HI=0x00. START=1 while RESET=1 is not accepted.
- Basic multiply: DATA1=3, DATA2=5, START pulse -> BUSY high 8 cycles; DONE pulses 1 cycle in cycle 9; RESULT=0x0F, RESULT_HI=0x00. Values are held afterwards.
- Full range: DATA1=0xFF, DATA2=0xFF -> RESULT=0x01, RESULT_HI=0xFE. Also DATA1=0x80, DATA2=0x02 -> RESULT=0x00, RESULT_HI=0x01.
- Ignored START: DATA1=4, DATA2=4, then during RUN change DATA1=9, DATA2=9 and pulse START at cycle 3 -> single DONE pulse; RESULT=0x10. No second run starts; BUSY=0 after DONE.
- Reset mid-operation: start 7*9, assert RESET in cycle 4 -> next cycle BUSY=0, DONE=0, RESULT=0. No DONE pulse follows. A new 2*3 then gives RESULT=0x06.
- Early termination: DATA1=3, DATA2=2.
  - With SEQ_MULT_EARLY_TERM_EN: BUSY for 2 cycles, DONE in cycle 3, RESULT=0x06.
  - Without it: DONE in cycle 9, RESULT=0x06.
  - DATA2=0 with the macro: DONE in cycle 2, RESULT=0.
